// File: rtl/axis_slave_capture.sv
// ---------------------------------------------------------------------------
// axis_slave_capture
//
// AXI-Stream slave that captures one frame of up to trans_lenth words into an
// internal buffer each time it is armed. The frame length is checked against
// s_tlast. A one-cycle done pulse, the word count and a length-error flag
// report the result. A registered read port gives access to the buffer.
//
// Optional build macro: AXIS_SLAVE_CHECKSUM_EN
//   When defined, adds output csum, which is the modulo-2^data_width sum of
//   the accepted words of the current or last frame.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   s_data    stream data
//   s_valid   stream valid
//   s_tlast   last word of frame
//   s_ready   slave ready (registered)
//   en        arm capture; sampled in IDLE only
//   done      one-cycle pulse when a frame capture ends
//   err_len   frame length error, held until next arm
//   word_cnt  words accepted in current/last frame (0..trans_lenth)
//   rd_addr   buffer read address
//   rd_data   buffer read data, 1-cycle latency
//   csum      running data checksum (AXIS_SLAVE_CHECKSUM_EN only)
//
// State table:
//   state | meaning
//   IDLE  | not ready; waits for en to arm a capture
//   RECV  | s_ready high; each handshake writes one buffer word
//   DONE  | single cycle with done high, then back to IDLE
// ---------------------------------------------------------------------------
module axis_slave_capture #(
    parameter int data_width  = 32,
    parameter int trans_width = 4,
    parameter int trans_lenth = 2**trans_width
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [data_width-1:0]  s_data,
    input  logic                   s_valid,
    input  logic                   s_tlast,
    output logic                   s_ready,
    input  logic                   en,
    output logic                   done,
    output logic                   err_len,
    output logic [trans_width:0]   word_cnt,
    input  logic [trans_width-1:0] rd_addr,
`ifdef AXIS_SLAVE_CHECKSUM_EN
    output logic [data_width-1:0]  rd_data,
    output logic [data_width-1:0]  csum
`else
    output logic [data_width-1:0]  rd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [trans_width-1:0] CNT_LAST = trans_width'(trans_lenth - 1);
    localparam logic [trans_width-1:0] CNT_ONE  = trans_width'(1);
    localparam logic [trans_width:0]   WC_ONE   = (trans_width + 1)'(1);

    state_t                 state;
    logic [trans_width-1:0] cnt;
    logic [data_width-1:0]  mem [trans_lenth];

    logic hs;
    logic wr_en;
    logic at_last;

    assign hs      = s_valid && s_ready;
    assign wr_en   = hs && (state == RECV);
    assign at_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            done     <= 1'b0;
            err_len  <= 1'b0;
            word_cnt <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        state    <= RECV;
                        s_ready  <= 1'b1;
                        word_cnt <= '0;
                        err_len  <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        s_ready <= 1'b0;
                    end
                end
                RECV: begin
                    done <= 1'b0;
                    if (hs) begin
                        word_cnt <= word_cnt + WC_ONE;
                        if (s_tlast || at_last) begin
                            // Error when tlast and the buffer end disagree:
                            // early tlast or a full frame without tlast.
                            err_len <= (s_tlast != at_last);
                            state   <= DONE;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Buffer is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt] <= s_data;
        end
    end

    // Non-blocking read of the same array gives read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef AXIS_SLAVE_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (state == IDLE && en) begin
            csum <= '0;
        end else if (wr_en) begin
            csum <= csum + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_axis_slave_capture.sv
module tb_axis_slave_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_tlast;
    logic        s_ready;
    logic        en;
    logic        done;
    logic        err_len;
    logic [4:0]  word_cnt;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef AXIS_SLAVE_CHECKSUM_EN
    logic [31:0] csum;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model_mem [16];
    bit          model_ok  [16];
    logic [31:0] exp_csum;

    always #5 clk = ~clk;

    axis_slave_capture dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_tlast  (s_tlast),
        .s_ready  (s_ready),
        .en       (en),
        .done     (done),
        .err_len  (err_len),
        .word_cnt (word_cnt),
        .rd_addr  (rd_addr),
`ifdef AXIS_SLAVE_CHECKSUM_EN
        .rd_data  (rd_data),
        .csum     (csum)
`else
        .rd_data  (rd_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic arm();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        exp_csum = '0;
        check("arm_ready", 32'(s_ready), 32'd1);
        check("arm_wcnt", 32'(word_cnt), 32'd0);
        check("arm_err", 32'(err_len), 32'd0);
    endtask

    // Drives n words; every word is expected to be accepted, so it is pushed
    // to the scoreboard and the buffer model as it is driven.
    task automatic send_words(input int n, input logic [31:0] base, input int tlast_idx,
                              input bit gaps, input int en_idx);
        for (int i = 0; i < n; i++) begin
            logic [31:0] old;
            bit          had;
            rd_addr = 4'(i);
            if (gaps) begin
                s_valid = 1'b0;
                s_tlast = 1'b0;
                en      = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = base + 32'(i);
            s_tlast = (i == tlast_idx);
            en      = (i == en_idx);
            old = model_mem[i];
            had = model_ok[i];
            model_mem[i] = s_data;
            model_ok[i]  = 1'b1;
            exp_q.push_back(s_data);
            exp_csum = exp_csum + s_data;
            @(negedge clk);
            if (had) check("rd_before_wr", rd_data, old);
        end
        s_valid = 1'b0;
        s_tlast = 1'b0;
        en      = 1'b0;
    endtask

    task automatic finish_frame(input int exp_cnt, input bit exp_err);
        check("done_pulse", 32'(done), 32'd1);
        check("ready_drop", 32'(s_ready), 32'd0);
        check("word_cnt", 32'(word_cnt), 32'(exp_cnt));
        check("err_len", 32'(err_len), 32'(exp_err));
`ifdef AXIS_SLAVE_CHECKSUM_EN
        check("csum", csum, exp_csum);
`endif
        @(negedge clk);
        check("done_end", 32'(done), 32'd0);
        check("wcnt_hold", 32'(word_cnt), 32'(exp_cnt));
        check("err_hold", 32'(err_len), 32'(exp_err));
    endtask

    task automatic read_back(input int n);
        for (int a = 0; a < n; a++) begin
            rd_addr = 4'(a);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL readback: scoreboard empty at addr %0d", a);
            end else begin
                check("readback", rd_data, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_tlast  = 1'b0;
        en       = 1'b0;
        rd_addr  = '0;
        exp_csum = '0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
            model_ok[i]  = 1'b0;
        end

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_len), 32'd0);
        check("rst_wcnt", 32'(word_cnt), 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Idle hold: valid without arming is ignored
        s_valid = 1'b1;
        s_data  = 32'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_ready", 32'(s_ready), 32'd0);
            check("idle_wcnt", 32'(word_cnt), 32'd0);
        end
        s_valid = 1'b0;

        // Normal frame 0..15
        arm();
        send_words(16, 32'd0, 15, 1'b0, -1);
        finish_frame(16, 1'b0);
`ifdef AXIS_SLAVE_CHECKSUM_EN
        check("csum_120", csum, 32'd120);
`endif
        read_back(16);

        // Same frame with alternate-cycle valid gaps
        arm();
        send_words(16, 32'd0, 15, 1'b1, -1);
        finish_frame(16, 1'b0);
        read_back(16);

        // Early tlast on the 4th word
        arm();
        send_words(4, 32'hA0, 3, 1'b0, -1);
        finish_frame(4, 1'b1);
        read_back(4);

        // Missing tlast: ends at full length with error
        arm();
        send_words(16, 32'h100, -1, 1'b0, -1);
        finish_frame(16, 1'b1);
        s_valid = 1'b1;
        s_data  = 32'hDEAD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("extra_ready", 32'(s_ready), 32'd0);
            check("extra_wcnt", 32'(word_cnt), 32'd16);
        end
        s_valid = 1'b0;
        read_back(16);

        // Arm pulse while receiving has no effect
        arm();
        send_words(16, 32'h200, 15, 1'b0, 8);
        finish_frame(16, 1'b0);
        read_back(16);

        // Reset mid-frame after 7 words
        arm();
        send_words(7, 32'h280, -1, 1'b0, -1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(s_ready), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err_len), 32'd0);
        check("mid_rst_wcnt", 32'(word_cnt), 32'd0);
        check("mid_rst_rdata", rd_data, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(s_ready), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        arm();
        send_words(16, 32'h300, 15, 1'b0, -1);
        finish_frame(16, 1'b0);
        read_back(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_slave_capture.md
Name: axis_slave_capture

Overview:
AXI-Stream slave stage that sits directly downstream of the AXIS burst master and consumes its frames. When armed by `en`, it accepts one frame of up to trans_lenth words into an internal buffer and checks the frame length against `s_tlast`. It then reports completion and word count. The captured words can be read back through a registered read port.

Parameters:
data_width, 32, width of stream data and buffer words
trans_width, 4, buffer address width
trans_lenth, 2**trans_width, maximum words per frame (buffer depth)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
s_data  input  data_width  stream data
s_valid  input  1  stream valid
s_tlast  input  1  last word of frame
s_ready  output  1  slave ready, registered
en  input  1  arm capture; sampled in IDLE only
done  output  1  one-cycle pulse when frame capture ends
err_len  output  1  frame length error flag, held until next arm
word_cnt  output  trans_width+1  words accepted in current/last frame
rd_addr  input  trans_width  buffer read address
rd_data  output  data_width  buffer read data, 1-cycle latency

Behaviour:
- Reset (rst=0, async): state IDLE; s_ready=0, done=0, err_len=0, word_cnt=0, rd_data=0, internal counter=0. Buffer contents are not cleared.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is produced.
- Handshake: hs = s_valid && s_ready. Words presented while s_ready=0 are ignored.
- State IDLE:
  - s_ready=0.
  - If en=1: next state RECV. In the same edge, clear word_cnt, err_len and the write counter.
- State RECV:
  - s_ready is registered as (next state == RECV). It is therefore 1 from the first cycle in RECV and drops the cycle after the final handshake.
  - Each hs writes mem[cnt] <= s_data and increments cnt and word_cnt.
  - The frame ends on hs with s_tlast=1, or on hs with cnt==trans_lenth-1. On either, next state is DONE.
  - Early tlast: hs with s_tlast=1 and cnt<trans_lenth-1 sets err_len=1. The frame ends short.
  - Missing tlast: hs with cnt==trans_lenth-1 and s_tlast=0 sets err_len=1. The frame ends at full length.
  - Normal case: s_tlast=1 exactly on word trans_lenth-1 leaves err_len=0.
  - `s_valid` gaps of any length are tolerated; state and counters hold.
  - en is ignored.
- State DONE:
  - Lasts exactly 1 cycle; done=1 during it and s_ready=0. Next state IDLE.
  - Any hs cannot occur, because s_ready=0.
- Outputs word_cnt and err_len hold their values after DONE until the next arming en.
- Read port: rd_data <= mem[rd_addr] every cycle, valid in any state.
  - A read of the address being written in the same cycle returns the old word (read-before-write).
- Width rules:
  - word_cnt ranges 0..trans_lenth and never wraps.
  - The internal write counter is trans_width bits and is never incremented past trans_lenth-1.

Optional Feature:
- Macro: AXIS_SLAVE_CHECKSUM_EN.
- Defined:
  - Adds output port `csum` [data_width-1:0], reset 0.
  - csum is cleared on arm and accumulates s_data modulo 2^data_width on every hs.
  - It holds after DONE until the next arm.
- Undefined: the port and the adder are absent. All other behaviour is identical.

Test Plan:
- Normal frame:
  - Stimulus: arm with en=1 one cycle; send 16 words of value 0..15, s_valid continuous, s_tlast on word 15.
  - Required: done pulses 1 cycle after the last hs; word_cnt=16; err_len=0; s_ready=0 after the last hs.
  - Readback: rd_addr=5 returns rd_data=5 next cycle.
  - With checksum compiled in: csum=120.
- Backpressure/gaps: same frame with s_valid low on alternate cycles -> identical results to the normal frame; no word duplicated or lost (rd 0..15 equals 0..15).
- Early tlast: data 0xA0..0xA3 with s_tlast on the 4th word -> done pulse; word_cnt=4; err_len=1; rd_addr=3 returns 0xA3.
- Missing tlast: 16 words, s_tlast never set -> frame ends after word 16; word_cnt=16; err_len=1; s_ready=0 thereafter, so a 17th presented word is not accepted.
- Arm while busy: pulse en again at word 8 -> no effect; the frame completes with word_cnt=16.
- Idle hold: s_valid=1 in IDLE without en -> s_ready stays 0 and word_cnt is unchanged.
- Reset mid-frame: assert rst=0 after 7 words -> s_ready, done, err_len, word_cnt and rd_data all 0 asynchronously. After release the block sits in IDLE, and a fresh armed 16-word frame captures correctly.
